// File: rtl/mem_rr_scheduler.sv
// mem_rr_scheduler: round-robin arbiter sharing one Sysbus between the L1
// I-cache and D-cache. One transaction is outstanding at a time; read bursts
// are steered back to the cache that issued the request.
// Optional feature: define ARB_TIMEOUT_EN to add a watchdog that aborts a
// stalled ISSUE/RESP phase after TIMEOUT cycles and pulses arb_timeout.
module mem_rr_scheduler #(
  parameter int WIDTH     = 64,
  parameter int TAG_WIDTH = 13,
  parameter int BURST     = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  // I-cache side
  input  logic                 i_reqcyc,
  input  logic [WIDTH-1:0]     i_req,
  input  logic [TAG_WIDTH-1:0] i_reqtag,
  output logic                 i_reqack,
  output logic                 i_respcyc,
  output logic [WIDTH-1:0]     i_resp,
  output logic [TAG_WIDTH-1:0] i_resptag,
  // D-cache side
  input  logic                 d_reqcyc,
  input  logic [WIDTH-1:0]     d_req,
  input  logic [TAG_WIDTH-1:0] d_reqtag,
  output logic                 d_reqack,
  output logic                 d_respcyc,
  output logic [WIDTH-1:0]     d_resp,
  output logic [TAG_WIDTH-1:0] d_resptag,
  // Sysbus side
  output logic                 bus_reqcyc,
  output logic [WIDTH-1:0]     bus_req,
  output logic [TAG_WIDTH-1:0] bus_reqtag,
  input  logic                 bus_reqack,
  input  logic                 bus_respcyc,
  input  logic [WIDTH-1:0]     bus_resp,
  input  logic [TAG_WIDTH-1:0] bus_resptag,
  output logic                 bus_respack,
  output logic                 arb_timeout
);

  localparam int BCW = $clog2(BURST + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t         state;
  logic           last_grant_d;  // 1: D-cache was granted most recently
  logic           owner_d;       // 1: current transaction belongs to the D-cache
  logic [BCW-1:0] beat_cnt;

  logic i_elig;
  logic d_elig;
  logic grant_any;
  logic grant_d;
  logic is_write;
  logic beat_ok;
  logic last_beat;
  logic wd_abort;

  // A request whose reqack is pulsing this cycle has already been issued; the
  // cache may still be holding reqcyc while it reacts, so it must not re-win.
  assign i_elig    = i_reqcyc & ~i_reqack;
  assign d_elig    = d_reqcyc & ~d_reqack;
  assign grant_any = i_elig | d_elig;

  // Pick the requester to grant: sole requester wins, ties go away from last_grant.
  always_comb begin
    grant_d = 1'b0;
    if (d_elig && !i_elig) begin
      grant_d = 1'b1;
    end else if (d_elig && i_elig) begin
      grant_d = ~last_grant_d;
    end
  end

  // bus_reqtag keeps the issued tag after the handshake, so it doubles as the
  // reference for matching response beats.
  assign is_write    = bus_reqtag[TAG_WIDTH-1];
  assign bus_respack = (state == S_RESP) && bus_respcyc;
  assign beat_ok     = bus_respack && (bus_resptag == bus_reqtag);
  assign last_beat   = (beat_cnt == BCW'(BURST - 1));

`ifdef ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        wd_progress;
  logic        wd_hit;

  assign wd_progress = ((state == S_ISSUE) && bus_reqack) || bus_respack;
  assign wd_hit      = (state != S_IDLE) && (wd_cnt == 16'(TIMEOUT - 1));
  assign wd_abort    = wd_hit && !wd_progress;

  // Watchdog: counts cycles spent in ISSUE/RESP without forward progress.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_cnt      <= '0;
      arb_timeout <= 1'b0;
    end else begin
      arb_timeout <= 1'b0;
      if ((state == S_IDLE) || wd_progress) begin
        wd_cnt <= '0;
      end else if (wd_abort) begin
        wd_cnt      <= '0;
        arb_timeout <= 1'b1;
      end else begin
        wd_cnt <= wd_cnt + 16'd1;
      end
    end
  end
`else
  assign wd_abort    = 1'b0;
  assign arb_timeout = 1'b0;
`endif

  // Arbitration / issue / response-routing FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      last_grant_d <= 1'b1;
      owner_d      <= 1'b0;
      beat_cnt     <= '0;
      bus_reqcyc   <= 1'b0;
      bus_req      <= '0;
      bus_reqtag   <= '0;
      i_reqack     <= 1'b0;
      d_reqack     <= 1'b0;
      i_respcyc    <= 1'b0;
      i_resp       <= '0;
      i_resptag    <= '0;
      d_respcyc    <= 1'b0;
      d_resp       <= '0;
      d_resptag    <= '0;
    end else begin
      i_reqack  <= 1'b0;
      d_reqack  <= 1'b0;
      i_respcyc <= 1'b0;
      d_respcyc <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            owner_d      <= grant_d;
            last_grant_d <= grant_d;
            bus_req      <= grant_d ? d_req    : i_req;
            bus_reqtag   <= grant_d ? d_reqtag : i_reqtag;
            bus_reqcyc   <= 1'b1;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus_reqack) begin
            bus_reqcyc <= 1'b0;
            i_reqack   <= ~owner_d;
            d_reqack   <= owner_d;
            beat_cnt   <= '0;
            state      <= is_write ? S_IDLE : S_RESP;
          end else if (wd_abort) begin
            bus_reqcyc <= 1'b0;
            state      <= S_IDLE;
          end
        end
        S_RESP: begin
          if (beat_ok) begin
            if (owner_d) begin
              d_respcyc <= 1'b1;
              d_resp    <= bus_resp;
              d_resptag <= bus_resptag;
            end else begin
              i_respcyc <= 1'b1;
              i_resp    <= bus_resp;
              i_resptag <= bus_resptag;
            end
            if (last_beat) begin
              beat_cnt <= '0;
              state    <= S_IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end else if (wd_abort) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
